clk_step_ctrl: RTL and testbench

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

---
 rtl/clk_ctrl_pkg.sv | 20 ++
 rtl/en_divider.sv | 54 +++++
 rtl/clk_step_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_clk_step_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_ctrl_pkg
//   Shared definitions for the clock-step controller:
//     - ctrl_state_e : FSM state encoding, also driven out on the 'state' port
//     - STEP_W_DEF   : default width of the burst-length input
//     - CYC_W_DEF    : default width of the enabled-cycle counter
//   Optional feature macro used by the controller: CLK_DIV_EN (enable divider).
// -----------------------------------------------------------------------------
package clk_ctrl_pkg;

  localparam int STEP_W_DEF = 8;
  localparam int CYC_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/en_divider.sv
// -----------------------------------------------------------------------------
// en_divider
//   Phase counter that paces the controller's enables to one every div+1
//   active cycles. Only instantiated when CLK_DIV_EN is defined.
//
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset (phase and ratio cleared)
//     start_i  : controller leaves HALTED this edge; latch div_i, restart phase
//     active_i : controller is in an active state; advance the phase
//     div_i    : divider ratio (enable every div_i+1 cycles)
//     fire_o   : the next cycle is an enable cycle (combinational from regs)
//
//   Phase semantics: phase_q counts the cycles elapsed since the last enable
//   was launched. The controller itself launches the first enable on the
//   start edge; afterwards an enable is launched whenever phase_q == div_q.
// -----------------------------------------------------------------------------
module en_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             active_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             fire_o
);

  logic [DIV_W-1:0] div_q,   div_d;
  logic [DIV_W-1:0] phase_q, phase_d;

  always_comb begin
    fire_o  = (phase_q == div_q);
    div_d   = div_q;
    phase_d = phase_q;
    if (start_i) begin
      div_d   = div_i;
      phase_d = '0;
    end else if (active_i) begin
      phase_d = fire_o ? '0 : phase_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      phase_q <= '0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// -----------------------------------------------------------------------------
// clk_step_ctrl
//   Run / halt / single-burst controller producing a registered one-cycle
//   clock enable for a downstream datapath, plus a count of enabled cycles.
//
//   Optional feature: define CLK_DIV_EN to add the 'div' input and pace the
//   enables to one every div+1 active cycles (en_divider sub-module).
//
//   Parameters:
//     STEP_W : width of step_count
//     CYC_W  : width of cycle_cnt
//
//   Ports:
//     clk        : single clock, rising edge
//     rst        : synchronous active-high reset, overrides all requests
//     run_req    : start free-running operation
//     halt_req   : stop issuing enables (done pulse if something was active)
//     step_req   : start a burst of step_count enables
//     step_count : burst length, sampled with step_req (0 means ignore)
//     clr_cnt    : clear cycle_cnt (wins over a coincident increment)
//     div        : enable divider ratio (CLK_DIV_EN builds only)
//     clk_en     : registered one-cycle enable to the controlled datapath
//     state      : current FSM state, encoded as clk_ctrl_pkg::ctrl_state_e
//     done       : one-cycle pulse on burst completion or on halt
//     cycle_cnt  : number of cycles with clk_en high, wraps at 2^CYC_W
//
//   Request semantics: run_req, halt_req and step_req are level inputs
//   sampled on every rising edge; there is no acknowledge. When several are
//   high together, halt_req beats run_req beats step_req. Requests that do
//   not apply to the current state are dropped, not queued.
//
//   Timing: clk_en, done and state all update on the same edge. The edge
//   that accepts run_req/step_req already launches the first enable, so
//   clk_en is high in the first cycle that state shows RUNNING/STEPPING.
//   In a burst, done rides with the last enable while state still shows
//   STEPPING; the FSM returns to HALTED on the edge that ends that cycle.
// -----------------------------------------------------------------------------
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int CYC_W  = CYC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic              clr_cnt,
`ifdef CLK_DIV_EN
  input  logic [7:0]        div,
`endif
  output logic              clk_en,
  output logic [1:0]        state,
  output logic              done,
  output logic [CYC_W-1:0]  cycle_cnt
);

  ctrl_state_e       state_q,     state_d;
  logic              clk_en_q,    clk_en_d;
  logic              done_q,      done_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic [CYC_W-1:0]  cycle_cnt_q, cycle_cnt_d;

  logic step_ok;
  logic div_fire;

  // A zero-length burst request is treated as if step_req were low.
  assign step_ok = step_req && (step_count != '0);

  // ---------------------------------------------------------------------------
  // Enable pacing
  // ---------------------------------------------------------------------------
`ifdef CLK_DIV_EN
  logic div_start;
  logic div_active;

  // The ratio is captured only when leaving HALTED; a STEPPING->RUNNING
  // conversion keeps the cadence already in progress.
  assign div_start  = (state_q == ST_HALTED) && (state_d != ST_HALTED);
  assign div_active = (state_q != ST_HALTED);

  en_divider #(
    .DIV_W(8)
  ) u_en_divider (
    .clk      (clk),
    .rst      (rst),
    .start_i  (div_start),
    .active_i (div_active),
    .div_i    (div),
    .fire_o   (div_fire)
  );
`else
  assign div_fire = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: begin
        // halt_req here is a no-op, but it still masks run/step.
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (run_req) begin
          state_d = ST_RUNNING;
        end else if (step_ok) begin
          state_d = ST_STEPPING;
        end
      end
      ST_RUNNING: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end
      end
      ST_STEPPING: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (run_req) begin
          state_d = ST_RUNNING;
        end else if (remaining_q == '0) begin
          // Final enable is in flight this cycle; burst is over.
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values
  //   remaining_q holds the enables of the burst not yet launched. The entry
  //   edge loads step_count and launches the first one in the same edge, so
  //   it reads step_count-1 in the first STEPPING cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    clk_en_d    = 1'b0;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    case (state_q)
      ST_HALTED: begin
        if (state_d == ST_RUNNING) begin
          clk_en_d = 1'b1;
        end else if (state_d == ST_STEPPING) begin
          clk_en_d    = 1'b1;
          remaining_d = step_count - STEP_W'(1);
          done_d      = (step_count == STEP_W'(1));
        end
      end
      ST_RUNNING: begin
        if (state_d == ST_RUNNING) begin
          clk_en_d = div_fire;
        end else begin
          done_d = 1'b1;
        end
      end
      ST_STEPPING: begin
        if (state_d == ST_HALTED) begin
          // A halt in the final enable cycle must not add a second done.
          done_d      = halt_req && (remaining_q != '0);
          remaining_d = '0;
        end else if (state_d == ST_RUNNING) begin
          clk_en_d    = div_fire;
          remaining_d = '0;
        end else if (div_fire) begin
          clk_en_d    = 1'b1;
          remaining_d = remaining_q - STEP_W'(1);
          done_d      = (remaining_q == STEP_W'(1));
        end
      end
      default: begin
        remaining_d = '0;
      end
    endcase
  end

  // Clear has priority over the count of a coincident enable cycle.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (clr_cnt) begin
      cycle_cnt_d = '0;
    end else if (clk_en_q) begin
      cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_en_q    <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      clk_en_q    <= clk_en_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign done      = done_q;
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_step_ctrl
//   Self-checking bench for clk_step_ctrl (STEP_W=8, CYC_W=4 so the cycle
//   counter wrap is reachable). Inputs change on the falling edge; outputs
//   are sampled on the falling edge after each rising edge.
//   Each expected word is {state[1:0], clk_en, done, cycle_cnt[3:0]}.
//   Build with +define+CLK_DIV_EN to add the divider scenario.
// -----------------------------------------------------------------------------
module tb_clk_step_ctrl;
  import clk_ctrl_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       run_req;
  logic       halt_req;
  logic       step_req;
  logic [7:0] step_count;
  logic       clr_cnt;
`ifdef CLK_DIV_EN
  logic [7:0] div;
`endif
  logic       clk_en;
  logic [1:0] state;
  logic       done;
  logic [3:0] cycle_cnt;

  clk_step_ctrl #(
    .STEP_W(8),
    .CYC_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .step_count (step_count),
    .clr_cnt    (clr_cnt),
`ifdef CLK_DIV_EN
    .div        (div),
`endif
    .clk_en     (clk_en),
    .state      (state),
    .done       (done),
    .cycle_cnt  (cycle_cnt)
  );

  localparam logic [1:0] H = 2'(ST_HALTED);
  localparam logic [1:0] R = 2'(ST_RUNNING);
  localparam logic [1:0] S = 2'(ST_STEPPING);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic [3:0] m_cnt;
  int         n_total = 0;
  int         n_bad   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d en=%0b done=%0b cnt=%0d, expected st=%0d en=%0b done=%0b cnt=%0d",
               tag, got[7:6], got[5], got[4], got[3:0], exp[7:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Push the expectation for the cycle after the next rising edge, advance,
  // then pop and compare. m_cnt tracks the enables seen so far.
  task automatic cyc(input string tag, input logic [1:0] st, input logic en, input logic dn);
    logic [7:0] got;
    exp_q.push_back({st, en, dn, m_cnt});
    @(posedge clk);
    @(negedge clk);
    got = {state, clk_en, done, cycle_cnt};
    check_eq(tag, got, exp_q.pop_front());
    if (en) m_cnt = m_cnt + 4'd1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset(input string tag);
    rst   = 1'b1;
    m_cnt = 4'd0;
    cyc(tag, H, 1'b0, 1'b0);
    rst   = 1'b0;
  endtask

  task automatic step_burst(input string tag, input int n);
    step_count = 8'(n);
    step_req   = 1'b1;
    for (int i = 1; i <= n; i++) begin
      cyc(tag, S, 1'b1, i == n);
      step_req = 1'b0;
    end
    cyc({tag, "_end"}, H, 1'b0, 1'b0);
  endtask

  task automatic halt_from_active(input string tag);
    halt_req = 1'b1;
    cyc(tag, H, 1'b0, 1'b1);
    halt_req = 1'b0;
    cyc({tag, "_after"}, H, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    run_req    = 1'b0;
    halt_req   = 1'b0;
    step_req   = 1'b0;
    step_count = 8'd0;
    clr_cnt    = 1'b0;
    m_cnt      = 4'd0;
`ifdef CLK_DIV_EN
    div        = 8'd0;
`endif
    @(negedge clk);

    do_reset("reset");

    // halt_req while HALTED: no response
    halt_req = 1'b1;
    cyc("halt_idle", H, 1'b0, 1'b0);
    halt_req = 1'b0;
    cyc("halt_idle2", H, 1'b0, 1'b0);

    // burst of 5: five enables, done with the fifth, cycle_cnt ends at 5
    step_burst("step5", 5);

    // run, halt 10 cycles later; a step_req mid-run is ignored
    do_reset("reset2");
    run_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step_count = 8'd3;
      step_req   = (k == 4);
      cyc("run10", R, 1'b1, 1'b0);
      run_req = 1'b0;
    end
    step_req = 1'b0;
    halt_from_active("halt_run");
    cyc("halt_run_idle", H, 1'b0, 1'b0);

    // run_req and halt_req together from HALTED: halt wins
    run_req  = 1'b1;
    halt_req = 1'b1;
    cyc("run_halt", H, 1'b0, 1'b0);
    run_req  = 1'b0;
    halt_req = 1'b0;
    cyc("run_halt2", H, 1'b0, 1'b0);

    // run_req and step_req together: run wins
    run_req    = 1'b1;
    step_req   = 1'b1;
    step_count = 8'd2;
    cyc("run_step", R, 1'b1, 1'b0);
    run_req  = 1'b0;
    step_req = 1'b0;
    cyc("run_step2", R, 1'b1, 1'b0);
    cyc("run_step3", R, 1'b1, 1'b0);
    halt_from_active("halt_rs");

    // zero-length burst: ignored
    step_count = 8'd0;
    step_req   = 1'b1;
    cyc("step0", H, 1'b0, 1'b0);
    step_req = 1'b0;
    cyc("step0_b", H, 1'b0, 1'b0);

    // single-enable burst
    step_burst("step1", 1);

    // halt in the middle of a burst
    step_count = 8'd5;
    step_req   = 1'b1;
    cyc("halt_step_a", S, 1'b1, 1'b0);
    step_req = 1'b0;
    cyc("halt_step_b", S, 1'b1, 1'b0);
    halt_from_active("halt_step");

    // run_req during a burst converts to RUNNING without done
    step_count = 8'd4;
    step_req   = 1'b1;
    cyc("s2r_a", S, 1'b1, 1'b0);
    step_req = 1'b0;
    run_req  = 1'b1;
    cyc("s2r_conv", R, 1'b1, 1'b0);
    run_req = 1'b0;
    for (int k = 0; k < 5; k++) cyc("s2r_run", R, 1'b1, 1'b0);
    halt_from_active("s2r_halt");

    // reset mid-burst (three enables still owed), with run_req also high
    step_count = 8'd5;
    step_req   = 1'b1;
    cyc("rst_mid_a", S, 1'b1, 1'b0);
    step_req = 1'b0;
    cyc("rst_mid_b", S, 1'b1, 1'b0);
    run_req = 1'b1;
    do_reset("rst_mid");
    run_req = 1'b0;
    cyc("rst_mid_idle", H, 1'b0, 1'b0);
    cyc("rst_mid_idle2", H, 1'b0, 1'b0);

    // 17 enables with a 4-bit counter: wraps to 1
    run_req = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cyc("wrap_run", R, 1'b1, 1'b0);
      run_req = 1'b0;
    end
    halt_from_active("wrap_halt");

    // clr_cnt on a cycle whose enable would otherwise count
    run_req = 1'b1;
    cyc("clr_a", R, 1'b1, 1'b0);
    run_req = 1'b0;
    cyc("clr_b", R, 1'b1, 1'b0);
    clr_cnt = 1'b1;
    m_cnt   = 4'd0;
    cyc("clr_en", R, 1'b1, 1'b0);
    clr_cnt = 1'b0;
    cyc("clr_c", R, 1'b1, 1'b0);
    halt_from_active("clr_halt");

    // random bursts with random idle gaps
    for (int r = 0; r < 6; r++) begin
      int n;
      int gap;
      n   = $urandom_range(1, 7);
      gap = $urandom_range(0, 2);
      step_burst("rand_step", n);
      for (int g = 0; g < gap; g++) cyc("rand_gap", H, 1'b0, 1'b0);
    end

`ifdef CLK_DIV_EN
    // div=2, burst of 3: enables in active cycles 1, 4, 7, done with the 7th
    div        = 8'd2;
    step_count = 8'd3;
    step_req   = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cyc("div_step", S, (i % 3) == 1, i == 7);
      step_req = 1'b0;
    end
    cyc("div_step_end", H, 1'b0, 1'b0);
    div = 8'd0;
`endif

    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL queue_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
